// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   x_sh_reg, y_sh_reg, res_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               br_reg, borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               xa, yb, d_bit, br_next, last_bit;
    logic [WIDTH-1:0]   res_next;

    // Full-subtractor cell fed by the operand LSBs and the running borrow
    assign xa       = x_sh_reg[0];
    assign yb       = y_sh_reg[0];
    assign d_bit    = xa ^ yb ^ br_reg;
    assign br_next  = (~xa & yb) | (~(xa ^ yb) & br_reg);
    assign res_next = {d_bit, res_reg[WIDTH-1:1]};
    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic x_msb_reg, y_msb_reg, ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh_reg   <= '0;
            y_sh_reg   <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb_reg  <= 1'b0;
            y_msb_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_sh_reg <= x;
                        y_sh_reg <= y;
                        br_reg   <= 1'b0;
                        cnt_reg  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        x_msb_reg <= x[WIDTH-1];
                        y_msb_reg <= y[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    x_sh_reg <= x_sh_reg >> 1;
                    y_sh_reg <= y_sh_reg >> 1;
                    res_reg  <= res_next;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    // Result registers are loaded only on the final bit so they stay stable in DONE
                    if (last_bit) begin
                        diff_reg   <= res_next;
                        borrow_reg <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_reg    <= (x_msb_reg != y_msb_reg) && (res_next[WIDTH-1] != x_msb_reg);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_reg;
`endif

endmodule
